// File: rtl/bram_word_loader.sv
// bram_word_loader: packs a little-endian byte stream into 32-bit words and
// writes them to consecutive word addresses on the bram_0 write port.
// One command (word base address + byte count) per load; done pulses once
// when the load has been fully written.
// Optional build macro: BRAM_LOADER_CHECKSUM_EN enables a running 32-bit sum
// of every word written during the current load (checksum output); when it is
// undefined, checksum is tied to zero.
module bram_word_loader #(
  parameter int unsigned ADDR_W   = 22,
  parameter int unsigned CNT_W    = 24,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic              bram_0_clk,
  input  logic              bram_0_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [CNT_W-1:0]  cmd_num_bytes,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic [ADDR_W-1:0] bram_0_addr,
  output logic              bram_0_en,
  output logic              bram_0_wr_en,
  output logic [31:0]       bram_0_wrdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_r;
  state_t next_state_s;

  logic [ADDR_W-1:0] addr_cnt_r;
  logic [ADDR_W-1:0] bram_addr_r;
  logic [CNT_W-1:0]  remaining_r;
  logic [1:0]        lane_idx_r;
  logic [31:0]       word_r;
  logic [31:0]       wrdata_r;
  logic [31:0]       packed_s;
  logic              cmd_take_s;
  logic              byte_take_s;
  logic              cmd_ready_r;
  logic              s_ready_r;
  logic              busy_r;
  logic              done_r;
  logic              bram_en_r;

  // Unfilled lanes start at the pad value so a short final word is padded.
  localparam logic [31:0] PAD_WORD = {4{PAD_BYTE}};

  // Place one byte into the selected lane of a word, leaving other lanes untouched.
  function automatic logic [31:0] insert_lane(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    case (lane)
      2'd0:    result[7:0]   = data;
      2'd1:    result[15:8]  = data;
      2'd2:    result[23:16] = data;
      2'd3:    result[31:24] = data;
      default: result        = word;
    endcase
    return result;
  endfunction

  // State register.
  always_ff @(posedge bram_0_clk) begin
    if (bram_0_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode plus the handshake strobes and the word being assembled.
  always_comb begin
    next_state_s = state_r;
    cmd_take_s   = 1'b0;
    byte_take_s  = 1'b0;
    packed_s     = word_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          cmd_take_s = 1'b1;
          if (cmd_num_bytes == {CNT_W{1'b0}}) begin
            next_state_s = DONE;
          end else begin
            next_state_s = COLLECT;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      COLLECT: begin
        if (s_valid && s_ready_r) begin
          byte_take_s = 1'b1;
          packed_s    = insert_lane(word_r, lane_idx_r, s_data);
          // Word is complete when lane 3 is filled or the stream runs out.
          if ((lane_idx_r == 2'd3) || (remaining_r == CNT_W'(1))) begin
            next_state_s = WRITE;
          end else begin
            next_state_s = COLLECT;
          end
        end else begin
          next_state_s = COLLECT;
        end
      end
      WRITE: begin
        if (remaining_r == {CNT_W{1'b0}}) begin
          next_state_s = DONE;
        end else begin
          next_state_s = COLLECT;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Registered outputs follow the next state so they line up with the state they describe.
  always_ff @(posedge bram_0_clk) begin
    if (bram_0_rst) begin
      cmd_ready_r <= 1'b1;
      s_ready_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      bram_en_r   <= 1'b0;
    end else begin
      cmd_ready_r <= (next_state_s == IDLE);
      s_ready_r   <= (next_state_s == COLLECT);
      busy_r      <= (next_state_s != IDLE);
      done_r      <= (next_state_s == DONE);
      bram_en_r   <= (next_state_s == WRITE);
    end
  end

  // Load datapath: address counter, byte countdown, lane index and word assembly.
  always_ff @(posedge bram_0_clk) begin
    if (bram_0_rst) begin
      addr_cnt_r  <= {ADDR_W{1'b0}};
      bram_addr_r <= {ADDR_W{1'b0}};
      remaining_r <= {CNT_W{1'b0}};
      lane_idx_r  <= 2'd0;
      word_r      <= PAD_WORD;
      wrdata_r    <= 32'h0000_0000;
    end else if (cmd_take_s) begin
      addr_cnt_r  <= cmd_base;
      remaining_r <= cmd_num_bytes;
      lane_idx_r  <= 2'd0;
      word_r      <= PAD_WORD;
    end else if (byte_take_s) begin
      remaining_r <= remaining_r - CNT_W'(1);
      if (next_state_s == WRITE) begin
        // Present the finished word; the assembly register restarts empty.
        bram_addr_r <= addr_cnt_r;
        wrdata_r    <= packed_s;
        lane_idx_r  <= 2'd0;
        word_r      <= PAD_WORD;
      end else begin
        lane_idx_r  <= lane_idx_r + 2'd1;
        word_r      <= packed_s;
      end
    end else if (state_r == WRITE) begin
      // Word address wraps naturally at 2^ADDR_W.
      addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
    end
  end

`ifdef BRAM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_r;

  // Running modulo-2^32 sum of the words written during the current load.
  always_ff @(posedge bram_0_clk) begin
    if (bram_0_rst) begin
      checksum_r <= 32'h0000_0000;
    end else if (cmd_take_s) begin
      checksum_r <= 32'h0000_0000;
    end else if (state_r == WRITE) begin
      checksum_r <= checksum_r + wrdata_r;
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = 32'h0000_0000;
`endif

  assign cmd_ready     = cmd_ready_r;
  assign s_ready       = s_ready_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign bram_0_en     = bram_en_r;
  assign bram_0_wr_en  = bram_en_r;
  assign bram_0_addr   = bram_addr_r;
  assign bram_0_wrdata = wrdata_r;

endmodule

// File: tb/tb_bram_word_loader.sv
// Scoreboard bench for bram_word_loader: a reference model turns each load
// into the list of expected word writes and the done event; a negedge monitor
// pops and compares whenever the DUT writes or pulses done.
module tb_bram_word_loader;

  localparam int         ADDR_W = 22;
  localparam int         CNT_W  = 24;
  localparam logic [7:0] PAD    = 8'h00;

  logic              clk = 1'b0;
  logic              bram_0_rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [CNT_W-1:0]  cmd_num_bytes;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic [ADDR_W-1:0] bram_0_addr;
  logic              bram_0_en;
  logic              bram_0_wr_en;
  logic [31:0]       bram_0_wrdata;
  logic              busy;
  logic              done;
  logic [31:0]       checksum;

  bram_word_loader dut (
    .bram_0_clk    (clk),
    .bram_0_rst    (bram_0_rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base      (cmd_base),
    .cmd_num_bytes (cmd_num_bytes),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .bram_0_addr   (bram_0_addr),
    .bram_0_en     (bram_0_en),
    .bram_0_wr_en  (bram_0_wr_en),
    .bram_0_wrdata (bram_0_wrdata),
    .busy          (busy),
    .done          (done),
    .checksum      (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                is_done;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  logic [7:0] byte_buf[$];
  int         wr_cyc_q[$];
  int         cyc        = 0;
  int         accept_cyc = 0;
  int         done_cyc   = 0;
  int         done_count = 0;
  int         n_checks   = 0;
  int         n_fail     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write and every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!bram_0_rst) begin
      if (bram_0_en || bram_0_wr_en) begin
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                   bram_0_addr, bram_0_wrdata);
        end else begin
          mon_ev = exp_q.pop_front();
          check("wr_en_pair", 64'({bram_0_en, bram_0_wr_en}), 64'(2'b11));
          check("wr_addr", 64'(bram_0_addr), 64'(mon_ev.addr));
          check("wr_data", 64'(bram_0_wrdata), 64'(mon_ev.data));
        end
      end
      if (done) begin
        done_cyc = cyc;
        done_count++;
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 with %0d writes pending, required 0",
                   exp_q.size());
        end else begin
          mon_ev = exp_q.pop_front();
          check("checksum_at_done", 64'(checksum), 64'(mon_ev.data));
          check("busy_at_done", 64'(busy), 64'(1));
        end
      end
    end
  end

  // Reference model: byte i of the load lands in word i/4, lane i%4; missing bytes are PAD.
  task automatic model_load(input logic [ADDR_W-1:0] base, input int n);
    logic [31:0] sum;
    logic [31:0] word;
    ev_t         e;
    sum = 32'h0;
    for (int w = 0; w < (n + 3) / 4; w++) begin
      for (int l = 0; l < 4; l++) begin
        if (4 * w + l < n) word[8*l +: 8] = byte_buf[4*w+l];
        else               word[8*l +: 8] = PAD;
      end
      e.is_done = 1'b0;
      e.addr    = base + ADDR_W'(w);
      e.data    = word;
      exp_q.push_back(e);
      sum = sum + word;
    end
    e.is_done = 1'b1;
    e.addr    = '0;
`ifdef BRAM_LOADER_CHECKSUM_EN
    e.data    = sum;
`else
    e.data    = 32'h0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic issue_cmd(input logic [ADDR_W-1:0] base, input int n, output bit ok);
    bit rdy;
    ok            = 1'b0;
    cmd_base      = base;
    cmd_num_bytes = CNT_W'(n);
    cmd_valid     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = cmd_ready;
      if (rdy) accept_cyc = cyc;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", 64'(ok), 64'(1));
  endtask

  // mode 0: s_valid held high; 1: toggles every cycle; 2: random with stray commands.
  task automatic run_load(input logic [ADDR_W-1:0] base, input int n, input int mode);
    bit ok;
    bit v;
    bit took;
    bit tog;
    int idx;
    int target;
    wr_cyc_q.delete();
    model_load(base, n);
    target = done_count + 1;
    issue_cmd(base, n, ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    idx = 0;
    tog = 1'b1;
    for (int k = 0; k < 400 && idx < n; k++) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      s_valid = v;
      s_data  = byte_buf[idx];
      if (mode == 2) begin
        cmd_valid     = 1'($urandom_range(0, 1));
        cmd_base      = ADDR_W'($urandom);
        cmd_num_bytes = CNT_W'($urandom_range(1, 9));
      end
      @(negedge clk);
      took = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (took) idx++;
    end
    s_valid   = 1'b0;
    cmd_valid = 1'b0;
    check("stream_consumed", 64'(idx), 64'(n));
    for (int k = 0; k < 40 && done_count < target; k++) @(posedge clk);
    #1;
    check("done_seen", 64'(done_count >= target), 64'(1));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"}, 64'(bram_0_en), 64'(0));
    check({tag, "_wr_en"}, 64'(bram_0_wr_en), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_s_ready"}, 64'(s_ready), 64'(0));
    check({tag, "_addr"}, 64'(bram_0_addr), 64'(0));
    check({tag, "_wrdata"}, 64'(bram_0_wrdata), 64'(0));
    check({tag, "_checksum"}, 64'(checksum), 64'(0));
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    bram_0_rst    = 1'b1;
    cmd_valid     = 1'b0;
    cmd_base      = '0;
    cmd_num_bytes = '0;
    s_valid       = 1'b0;
    s_data        = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    bram_0_rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;

    // 8 bytes 00..07 at 0x100, stream always valid; check timing too.
    byte_buf.delete();
    for (int i = 0; i < 8; i++) byte_buf.push_back(8'(i));
    run_load(22'h000100, 8, 0);
    check("t1_write_count", 64'(wr_cyc_q.size()), 64'(2));
    if (wr_cyc_q.size() == 2) begin
      check("t1_second_write_latency", 64'(wr_cyc_q[1] - accept_cyc), 64'(10));
      check("t1_done_after_write", 64'(done_cyc - wr_cyc_q[1]), 64'(1));
    end

    // 6 bytes: second word padded.
    byte_buf.delete();
    for (int i = 0; i < 6; i++) byte_buf.push_back(8'(i));
    run_load(22'h000040, 6, 0);
    check("t2_write_count", 64'(wr_cyc_q.size()), 64'(2));

    // Zero-byte load: done the cycle after accept, ready the cycle after that.
    byte_buf.delete();
    model_load(22'h000777, 0);
    issue_cmd(22'h000777, 0, ok);
    @(negedge clk);
    check("zero_done_next_cycle", 64'(done), 64'(1));
    check("zero_no_write", 64'(bram_0_en), 64'(0));
    @(negedge clk);
    check("zero_cmd_ready_back", 64'(cmd_ready), 64'(1));
    check("zero_done_single", 64'(done), 64'(0));
    check("zero_scoreboard_drained", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;

    // Address wrap with a toggling stream.
    byte_buf.delete();
    for (int i = 0; i < 8; i++) byte_buf.push_back(8'($urandom));
    run_load(22'h3FFFFF, 8, 1);
    check("wrap_write_count", 64'(wr_cyc_q.size()), 64'(2));

    // Reset after two bytes of a four-byte load: nothing written, outputs back to reset.
    issue_cmd(22'h000055, 4, ok);
    s_valid = 1'b1;
    s_data  = 8'h11;
    @(posedge clk);
    #1;
    s_data = 8'h22;
    @(posedge clk);
    #1;
    s_valid    = 1'b0;
    bram_0_rst = 1'b1;
    @(posedge clk);
    #1;
    bram_0_rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    byte_buf.delete();
    byte_buf.push_back(8'hAA);
    byte_buf.push_back(8'hBB);
    byte_buf.push_back(8'hCC);
    byte_buf.push_back(8'hDD);
    run_load(22'h000200, 4, 0);

    // Checksum pattern: words 1 and 2.
    byte_buf.delete();
    byte_buf.push_back(8'h01);
    repeat (3) byte_buf.push_back(8'h00);
    byte_buf.push_back(8'h02);
    repeat (3) byte_buf.push_back(8'h00);
    run_load(22'h000300, 8, 0);

    // Randomized loads with stalls and stray commands while busy.
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, 13);
      byte_buf.delete();
      for (int i = 0; i < n; i++) byte_buf.push_back(8'($urandom));
      if (t % 5 == 0) run_load(ADDR_W'(22'h3FFFFD + ADDR_W'($urandom_range(0, 2))), n, 2);
      else            run_load(ADDR_W'($urandom), n, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
